rvvi_trace_gen: RTL and testbench

Producer end of the RVVI trace used by the coverage collector. It accepts one retirement record per cycle from the core's commit stage over a valid/ready handshake, and buffers records in a small FIFO. It drives flattened RVVI signals (valid, order, insn, pc, trap, GPR writeback) into the rvviTrace interface, one instruction per cycle, single hart, single retire slot.

---
 rtl/rvvi_gen_pkg.sv | 40 ++++
 rtl/rvvi_retire_fifo.sv | 56 +++++
 rtl/rvvi_trace_gen.sv | 132 +++++++++++++
 tb/tb_rvvi_trace_gen.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvvi_gen_pkg.sv
// Shared types for the RVVI trace producer: the retirement record as stored in
// the FIFO, the freeze/run control state and the GPR write-mask decode.
`ifndef XLEN
`define XLEN 64
`endif
`ifndef ILEN
`define ILEN 32
`endif

package rvvi_gen_pkg;

    localparam int XLEN_P = `XLEN;
    localparam int ILEN_P = `ILEN;
    localparam int NGPR   = 32;

    typedef struct packed {
        logic [ILEN_P-1:0] insn;
        logic [XLEN_P-1:0] pc;
        logic              trap;
        logic              rd_wen;
        logic [4:0]        rd_addr;
        logic [XLEN_P-1:0] rd_data;
    } retire_rec_t;

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } trace_state_t;

    // x0 is hardwired and a trapped instruction never commits its write.
    function automatic logic [NGPR-1:0] wb_mask(input retire_rec_t rec);
        logic [NGPR-1:0] one;
        one = {{(NGPR-1){1'b0}}, 1'b1};
        if (rec.rd_wen && !rec.trap && (rec.rd_addr != 5'd0)) begin
            return one << rec.rd_addr;
        end
        return '0;
    endfunction

endpackage

// File: rtl/rvvi_retire_fifo.sv
// Generic synchronous FIFO with occupancy count; head data is read combinationally
// so a record can be popped the edge after it was pushed.
module rvvi_retire_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap without extra logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/rvvi_trace_gen.sv
// RVVI trace producer: buffers commit-stage retirement records and emits one
// instruction per cycle onto flattened rvviTrace signals (single hart, one slot).
module rvvi_trace_gen
    import rvvi_gen_pkg::*;
#(
    parameter int ILEN  = ILEN_P,
    parameter int XLEN  = XLEN_P,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ret_valid,
    output logic            ret_ready,
    input  logic [ILEN-1:0] ret_insn,
    input  logic [XLEN-1:0] ret_pc,
    input  logic            ret_trap,
    input  logic            ret_rd_wen,
    input  logic [4:0]      ret_rd_addr,
    input  logic [XLEN-1:0] ret_rd_data,
    input  logic            halt,
    output logic            rvvi_valid,
    output logic [63:0]     rvvi_order,
    output logic [ILEN-1:0] rvvi_insn,
    output logic [XLEN-1:0] rvvi_pc_rdata,
    output logic            rvvi_trap,
    output logic [NGPR-1:0] rvvi_x_wb,
    output logic [XLEN-1:0] rvvi_x_wdata,
    output logic            bp_seen
);
    localparam int CW = $clog2(DEPTH) + 1;

    retire_rec_t     wr_rec;
    retire_rec_t     head_rec;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    trace_state_t    state_q, state_d;
    logic [63:0]     order_q;
    logic [63:0]     order_d;
    logic            valid_q;
    logic [63:0]     rvvi_order_q;
    logic [ILEN-1:0] insn_q;
    logic [XLEN-1:0] pc_q;
    logic            trap_q;
    logic [NGPR-1:0] x_wb_q, x_wb_d;
    logic [XLEN-1:0] x_wdata_q, x_wdata_d;
    logic            bp_seen_q;

    assign wr_rec.insn    = ret_insn;
    assign wr_rec.pc      = ret_pc;
    assign wr_rec.trap    = ret_trap;
    assign wr_rec.rd_wen  = ret_rd_wen;
    assign wr_rec.rd_addr = ret_rd_addr;
    assign wr_rec.rd_data = ret_rd_data;

    // Ready comes from registered occupancy only: a pop never opens a slot
    // for a push in the same cycle.
    assign ret_ready = (fifo_count != CW'(DEPTH));
    assign push      = ret_valid && ret_ready;

    rvvi_retire_fifo #(
        .WIDTH ($bits(retire_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i (wr_rec),
        .pop_i   (pop),
        .rdata_o (head_rec),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // halt acts on the same edge it is seen, so pop follows the next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:    state_d = halt ? FROZEN : RUN;
            FROZEN: state_d = halt ? FROZEN : RUN;
        endcase
    end

    assign pop       = (state_d == RUN) && !fifo_empty;
    assign order_d   = order_q + 64'd1;
    assign x_wb_d    = wb_mask(head_rec);
    assign x_wdata_d = (x_wb_d != '0) ? head_rec.rd_data : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            order_q      <= '0;
            valid_q      <= 1'b0;
            rvvi_order_q <= '0;
            insn_q       <= '0;
            pc_q         <= '0;
            trap_q       <= 1'b0;
            x_wb_q       <= '0;
            x_wdata_q    <= '0;
            bp_seen_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= pop;
            if (ret_valid && fifo_full) begin
                bp_seen_q <= 1'b1;
            end
            if (pop) begin
                order_q      <= order_d;
                rvvi_order_q <= order_d;
                insn_q       <= head_rec.insn;
                pc_q         <= head_rec.pc;
                trap_q       <= head_rec.trap;
                x_wb_q       <= x_wb_d;
                x_wdata_q    <= x_wdata_d;
            end
        end
    end

    assign rvvi_valid    = valid_q;
    assign rvvi_order    = rvvi_order_q;
    assign rvvi_insn     = insn_q;
    assign rvvi_pc_rdata = pc_q;
    assign rvvi_trap     = trap_q;
    assign rvvi_x_wb     = x_wb_q;
    assign rvvi_x_wdata  = x_wdata_q;
    assign bp_seen       = bp_seen_q;

endmodule

// File: tb/tb_rvvi_trace_gen.sv
// Directed bench for rvvi_trace_gen: a negedge collector logs every emitted
// trace slot, and each scenario compares the log against hand-computed values.
module tb_rvvi_trace_gen;

    logic        clk;
    logic        reset_n;
    logic        ret_valid;
    logic        ret_ready;
    logic [31:0] ret_insn;
    logic [63:0] ret_pc;
    logic        ret_trap;
    logic        ret_rd_wen;
    logic [4:0]  ret_rd_addr;
    logic [63:0] ret_rd_data;
    logic        halt;
    logic        rvvi_valid;
    logic [63:0] rvvi_order;
    logic [31:0] rvvi_insn;
    logic [63:0] rvvi_pc_rdata;
    logic        rvvi_trap;
    logic [31:0] rvvi_x_wb;
    logic [63:0] rvvi_x_wdata;
    logic        bp_seen;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [63:0] obs_order[$];
    logic [63:0] obs_insn[$];
    logic [63:0] obs_pc[$];
    logic [63:0] obs_trap[$];
    logic [63:0] obs_wb[$];
    logic [63:0] obs_wdata[$];
    int          obs_cyc[$];

    rvvi_trace_gen #(.ILEN(32), .XLEN(64), .DEPTH(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ret_valid     (ret_valid),
        .ret_ready     (ret_ready),
        .ret_insn      (ret_insn),
        .ret_pc        (ret_pc),
        .ret_trap      (ret_trap),
        .ret_rd_wen    (ret_rd_wen),
        .ret_rd_addr   (ret_rd_addr),
        .ret_rd_data   (ret_rd_data),
        .halt          (halt),
        .rvvi_valid    (rvvi_valid),
        .rvvi_order    (rvvi_order),
        .rvvi_insn     (rvvi_insn),
        .rvvi_pc_rdata (rvvi_pc_rdata),
        .rvvi_trap     (rvvi_trap),
        .rvvi_x_wb     (rvvi_x_wb),
        .rvvi_x_wdata  (rvvi_x_wdata),
        .bp_seen       (bp_seen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n && rvvi_valid) begin
            obs_order.push_back(rvvi_order);
            obs_insn.push_back({32'd0, rvvi_insn});
            obs_pc.push_back(rvvi_pc_rdata);
            obs_trap.push_back({63'd0, rvvi_trap});
            obs_wb.push_back({32'd0, rvvi_x_wb});
            obs_wdata.push_back(rvvi_x_wdata);
            obs_cyc.push_back(cyc);
            $display("trace: cyc=%0d order=%0d insn=%08h pc=%0h trap=%0b wb=%08h wdata=%0h",
                     cyc, rvvi_order, rvvi_insn, rvvi_pc_rdata, rvvi_trap, rvvi_x_wb, rvvi_x_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic clear_log();
        obs_order.delete();
        obs_insn.delete();
        obs_pc.delete();
        obs_trap.delete();
        obs_wb.delete();
        obs_wdata.delete();
        obs_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        ret_valid = 1'b0;
        halt      = 1'b0;
        idle(2);
        reset_n = 1'b1;
        clear_log();
    endtask

    // Offers one record from a negedge and holds it until ret_ready was seen.
    task automatic send(input logic [31:0] insn, input logic [63:0] pc, input logic trap,
                        input logic wen, input logic [4:0] rd, input logic [63:0] data,
                        output logic stalled);
        int   t;
        logic acc;
        ret_insn    = insn;
        ret_pc      = pc;
        ret_trap    = trap;
        ret_rd_wen  = wen;
        ret_rd_addr = rd;
        ret_rd_data = data;
        ret_valid   = 1'b1;
        stalled     = 1'b0;
        t           = 0;
        do begin
            acc = ret_ready;
            if (!acc) stalled = 1'b1;
            @(negedge clk);
            t++;
        end while (!acc && t < 50);
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        ret_valid = 1'b0;
    endtask

    logic        st;
    logic        st_any;
    int          c_push;
    logic [31:0] m;

    initial begin
        reset_n     = 1'b1;
        ret_valid   = 1'b0;
        ret_insn    = '0;
        ret_pc      = '0;
        ret_trap    = 1'b0;
        ret_rd_wen  = 1'b0;
        ret_rd_addr = '0;
        ret_rd_data = '0;
        halt        = 1'b0;
        #1 reset_n = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", {63'd0, rvvi_valid}, 64'd0);
        check("rst_ready", {63'd0, ret_ready}, 64'd1);
        check("rst_order", rvvi_order, 64'd0);
        check("rst_wb", {32'd0, rvvi_x_wb}, 64'd0);
        check("rst_bp", {63'd0, bp_seen}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        clear_log();

        // Single addi x1,x0,5
        send(32'h00500093, 64'h80000000, 1'b0, 1'b1, 5'd1, 64'd5, st);
        c_push = cyc;
        idle(4);
        check("one_count", 64'(obs_order.size()), 64'd1);
        if (obs_order.size() >= 1) begin
            check("one_order", obs_order[0], 64'd1);
            check("one_insn", obs_insn[0], 64'h00500093);
            check("one_pc", obs_pc[0], 64'h80000000);
            check("one_trap", obs_trap[0], 64'd0);
            check("one_wb", obs_wb[0], 64'h00000002);
            check("one_wdata", obs_wdata[0], 64'd5);
            check("one_latency", 64'(obs_cyc[0] - c_push), 64'd1);
        end
        check("one_valid_drops", {63'd0, rvvi_valid}, 64'd0);

        // Ten back-to-back records, no halt
        do_reset();
        st_any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(32'h00100013 + 32'(i), 64'h80001000 + 64'(4 * i), 1'b0, 1'b1,
                 5'(i + 1), 64'h1000 + 64'(i), st);
            st_any = st_any | st;
        end
        idle(4);
        check("burst_stall", {63'd0, st_any}, 64'd0);
        check("burst_bp", {63'd0, bp_seen}, 64'd0);
        check("burst_count", 64'(obs_order.size()), 64'd10);
        if (obs_order.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                m = 32'd1 << (i + 1);
                check($sformatf("burst_order%0d", i), obs_order[i], 64'(i + 1));
                check($sformatf("burst_insn%0d", i), obs_insn[i], 64'h00100013 + 64'(i));
                check($sformatf("burst_wb%0d", i), obs_wb[i], {32'd0, m});
                if (i > 0) check($sformatf("burst_gap%0d", i), 64'(obs_cyc[i] - obs_cyc[i-1]), 64'd1);
            end
        end

        // Halt with six pushes into a four-deep FIFO
        do_reset();
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'h00A00013 + 32'(i), 64'h80002000 + 64'(4 * i), 1'b0, 1'b1, 5'd2, 64'(i), st);
        end
        ret_insn  = 32'h00A00017;
        ret_valid = 1'b1;
        check("halt_full_ready", {63'd0, ret_ready}, 64'd0);
        @(negedge clk);
        check("halt_bp", {63'd0, bp_seen}, 64'd1);
        check("halt_still_full", {63'd0, ret_ready}, 64'd0);
        check("halt_no_emit", 64'(obs_order.size()), 64'd0);
        check("halt_valid", {63'd0, rvvi_valid}, 64'd0);
        halt = 1'b0;
        send(32'h00A00017, 64'h80002010, 1'b0, 1'b1, 5'd2, 64'd4, st);
        check("halt_rec5_stalled", {63'd0, st}, 64'd1);
        send(32'h00A00018, 64'h80002014, 1'b0, 1'b1, 5'd2, 64'd5, st);
        idle(8);
        check("halt_count", 64'(obs_order.size()), 64'd6);
        if (obs_order.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("halt_order%0d", i), obs_order[i], 64'(i + 1));
                check($sformatf("halt_insn%0d", i), obs_insn[i], 64'h00A00013 + 64'(i));
                if (i > 0) check($sformatf("halt_gap%0d", i), 64'(obs_cyc[i] - obs_cyc[i-1]), 64'd1);
            end
        end
        check("halt_bp_sticky", {63'd0, bp_seen}, 64'd1);

        // Trap and x0 writes are masked; rd=31 is the top mask bit
        do_reset();
        send(32'h00000073, 64'h80003000, 1'b1, 1'b1, 5'd3, 64'hAA, st);
        send(32'h00700013, 64'h80003004, 1'b0, 1'b1, 5'd0, 64'hBB, st);
        send(32'h00900F93, 64'h80003008, 1'b0, 1'b1, 5'd31, 64'hCC, st);
        idle(4);
        check("mask_count", 64'(obs_order.size()), 64'd3);
        if (obs_order.size() == 3) begin
            check("trap_flag", obs_trap[0], 64'd1);
            check("trap_wb", obs_wb[0], 64'd0);
            check("trap_wdata", obs_wdata[0], 64'd0);
            check("trap_order", obs_order[0], 64'd1);
            check("x0_trap", obs_trap[1], 64'd0);
            check("x0_wb", obs_wb[1], 64'd0);
            check("x0_wdata", obs_wdata[1], 64'd0);
            check("x0_order", obs_order[1], 64'd2);
            check("x31_wb", obs_wb[2], 64'h80000000);
            check("x31_wdata", obs_wdata[2], 64'hCC);
        end

        // Order counter wrap
        do_reset();
        force dut.order_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.order_q;
        send(32'h00000013, 64'h80004000, 1'b0, 1'b0, 5'd0, 64'd0, st);
        send(32'h00000013, 64'h80004004, 1'b0, 1'b0, 5'd0, 64'd0, st);
        idle(4);
        check("wrap_count", 64'(obs_order.size()), 64'd2);
        if (obs_order.size() == 2) begin
            check("wrap_order0", obs_order[0], 64'd0);
            check("wrap_order1", obs_order[1], 64'd1);
        end

        // Asynchronous reset mid-burst
        do_reset();
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(32'h00B00013 + 32'(i), 64'h80005000 + 64'(4 * i), 1'b0, 1'b1, 5'd4, 64'(i), st);
        end
        halt = 1'b0;
        idle(2);
        check("prerst_valid", {63'd0, rvvi_valid}, 64'd1);
        check("prerst_order", rvvi_order, 64'd2);
        #2 reset_n = 1'b0;
        #1;
        check("async_valid", {63'd0, rvvi_valid}, 64'd0);
        check("async_ready", {63'd0, ret_ready}, 64'd1);
        check("async_order", rvvi_order, 64'd0);
        check("async_insn", {32'd0, rvvi_insn}, 64'd0);
        check("async_wb", {32'd0, rvvi_x_wb}, 64'd0);
        idle(2);
        reset_n = 1'b1;
        clear_log();
        send(32'h00C00013, 64'h80006000, 1'b0, 1'b1, 5'd5, 64'd9, st);
        idle(4);
        check("postrst_count", 64'(obs_order.size()), 64'd1);
        if (obs_order.size() == 1) begin
            check("postrst_order", obs_order[0], 64'd1);
            check("postrst_insn", obs_insn[0], 64'h00C00013);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
